// File: rtl/mips_pkg.sv
// Shared encodings and sizes for the MIPS multiply/divide unit.
package mips_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/mips_md_sign_fix.sv
// Conditional two's-complement negation: magnitude extraction on the way in,
// sign restoration of product/quotient/remainder on the way out.
module mips_md_sign_fix
  import mips_pkg::*;
#(
  parameter int BITS = WIDTH
) (
  input  logic [BITS-1:0] value,
  input  logic            negate,
  output logic [BITS-1:0] result
);

  assign result = negate ? -value : value;

endmodule

// File: rtl/mips_mult_div.sv
// Iterative MIPS multiply/divide unit holding HI/LO, one bit per clock.
// The divider datapath is only built when MIPS_MD_DIV_EN is defined.
module mips_mult_div #(
  parameter int WIDTH = mips_pkg::WIDTH,
  parameter int CNT_W = mips_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  import mips_pkg::*;

  md_state_t state, state_next;

  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   acc, shreg, b_mag;
  logic               neg_q;
  logic [WIDTH-1:0]   a_mag_in, b_mag_in;
  logic               op_mul, op_div, op_signed, last_iter;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   acc_next, sh_next, hi_res, lo_res;
  logic [2*WIDTH-1:0] prod_fix;

  assign op_mul    = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign op_div    = (md_op == MD_DIV) || (md_op == MD_DIVU);
  assign op_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
  assign last_iter = (count == CNT_W'(WIDTH - 1));

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  mips_md_sign_fix #(.BITS(WIDTH)) u_fix_a (
    .value  (operand_a),
    .negate (op_signed & operand_a[WIDTH-1]),
    .result (a_mag_in)
  );

  mips_md_sign_fix #(.BITS(WIDTH)) u_fix_b (
    .value  (operand_b),
    .negate (op_signed & operand_b[WIDTH-1]),
    .result (b_mag_in)
  );

  // Shift-add step: {acc, shreg} is the partial product, multiplier bits leave at the bottom.
  assign mul_sum = {1'b0, acc} + {1'b0, (shreg[0] ? b_mag : {WIDTH{1'b0}})};

  mips_md_sign_fix #(.BITS(2 * WIDTH)) u_fix_prod (
    .value  ({acc_next, sh_next}),
    .negate (neg_q),
    .result (prod_fix)
  );

`ifdef MIPS_MD_DIV_EN
  logic             is_div, neg_r, b_zero, dbz, q_bit, op_valid;
  logic [WIDTH-1:0] a_raw, quo_fix, rem_fix;
  logic [WIDTH:0]   r_shift, diff;

  assign op_valid = op_mul || op_div || (md_op == MD_MTHI) || (md_op == MD_MTLO);

  // Restoring step: acc is the partial remainder, shreg shifts dividend out and quotient in.
  assign r_shift = {acc, shreg[WIDTH-1]};
  assign diff    = r_shift - {1'b0, b_mag};
  assign q_bit   = ~diff[WIDTH];

  assign acc_next = is_div ? (q_bit ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0]) : mul_sum[WIDTH:1];
  assign sh_next  = is_div ? {shreg[WIDTH-2:0], q_bit} : {mul_sum[0], shreg[WIDTH-1:1]};

  mips_md_sign_fix #(.BITS(WIDTH)) u_fix_quo (
    .value  (sh_next),
    .negate (neg_q),
    .result (quo_fix)
  );

  mips_md_sign_fix #(.BITS(WIDTH)) u_fix_rem (
    .value  (acc_next),
    .negate (neg_r),
    .result (rem_fix)
  );

  always_comb begin
    {hi_res, lo_res} = prod_fix;
    if (is_div) begin
      if (b_zero) begin
        hi_res = a_raw;
        lo_res = '1;
      end else begin
        hi_res = rem_fix;
        lo_res = quo_fix;
      end
    end
  end

  assign div_by_zero = dbz;

  // The flag survives until the next accepted start, including MTHI/MTLO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_div <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      a_raw  <= '0;
      dbz    <= 1'b0;
    end else if (state == ST_IDLE && start && op_valid) begin
      is_div <= op_div;
      neg_r  <= op_signed & operand_a[WIDTH-1];
      b_zero <= (operand_b == '0);
      a_raw  <= operand_a;
      dbz    <= 1'b0;
    end else if (state == ST_RUN && last_iter) begin
      dbz <= is_div & b_zero;
    end
  end
`else
  assign acc_next         = mul_sum[WIDTH:1];
  assign sh_next          = {mul_sum[0], shreg[WIDTH-1:1]};
  assign {hi_res, lo_res} = prod_fix;
  assign div_by_zero      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (op_mul) state_next = ST_RUN;
`ifdef MIPS_MD_DIV_EN
          else if (op_div) state_next = ST_RUN;
`else
          else if (op_div) state_next = ST_DONE;
`endif
        end
      end
      ST_RUN:  if (last_iter) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      acc   <= '0;
      shreg <= '0;
      b_mag <= '0;
      neg_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (op_mul || op_div) begin
              acc   <= '0;
              shreg <= a_mag_in;
              b_mag <= b_mag_in;
              neg_q <= op_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
              count <= '0;
            end else if (md_op == MD_MTHI) begin
              hi <= operand_a;
            end else if (md_op == MD_MTLO) begin
              lo <= operand_a;
            end
          end
        end
        ST_RUN: begin
          acc   <= acc_next;
          shreg <= sh_next;
          count <= count + CNT_W'(1);
          if (last_iter) begin
            hi <= hi_res;
            lo <= lo_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mult_div.sv
// Directed, table-driven bench for mips_mult_div; adapts divide expectations
// to whether MIPS_MD_DIV_EN is defined.
module tb_mips_mult_div;

  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] operand_a, operand_b;
  logic [31:0] hi, lo;
  logic        busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_mult_div dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .md_op       (md_op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
  } vec_t;

  vec_t vecs [12];

  int          busy_cnt, lat, busy_pre, exp_busy, exp_lat;
  logic        seen, exp_dbz, saw_done;
  logic [31:0] exp_hi, exp_lo;
  logic [2:0]  seq_op;
`ifndef MIPS_MD_DIV_EN
  logic        is_div;
  logic [31:0] model_hi, model_lo;
`endif

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_op     = op;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Samples on falling edges until done, counting busy cycles and latency in cycles.
  task automatic waitDone(input int budget, output int n_busy, output int n_lat, output logic got);
    n_busy = 0;
    n_lat  = 0;
    got    = 1'b0;
    while (!got && n_lat < budget) begin
      @(negedge clk);
      n_lat++;
      if (done) got = 1'b1;
      else if (busy) n_busy++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    md_op     = 3'b000;
    operand_a = '0;
    operand_b = '0;
`ifndef MIPS_MD_DIV_EN
    model_hi = '0;
    model_lo = '0;
`endif

    vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{MD_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{MD_MULT,  32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 1'b0};
    vecs[5]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[7]  = '{MD_DIVU,  32'h000003E8, 32'h00000007, 32'h00000006, 32'h0000008E, 1'b0};
    vecs[8]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[10] = '{MD_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};
    vecs[11] = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};

    repeat (2) @(negedge clk);
    checkOutput("rst_hi", hi, 32'h0);
    checkOutput("rst_lo", lo, 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_dbz", 32'(div_by_zero), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
`ifdef MIPS_MD_DIV_EN
      exp_busy = 32;
      exp_lat  = 33;
      exp_hi   = vecs[i].exp_hi;
      exp_lo   = vecs[i].exp_lo;
      exp_dbz  = vecs[i].exp_dbz;
`else
      is_div  = (vecs[i].op == MD_DIV) || (vecs[i].op == MD_DIVU);
      exp_dbz = 1'b0;
      if (is_div) begin
        exp_busy = 0;
        exp_lat  = 1;
        exp_hi   = model_hi;
        exp_lo   = model_lo;
      end else begin
        exp_busy = 32;
        exp_lat  = 33;
        exp_hi   = vecs[i].exp_hi;
        exp_lo   = vecs[i].exp_lo;
      end
`endif
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      waitDone(100, busy_cnt, lat, seen);
      checkOutput($sformatf("v%0d_done_seen", i), 32'(seen), 32'h1);
      checkOutput($sformatf("v%0d_hi", i), hi, exp_hi);
      checkOutput($sformatf("v%0d_lo", i), lo, exp_lo);
      checkOutput($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(exp_dbz));
      checkOutput($sformatf("v%0d_busy_cycles", i), 32'(busy_cnt), 32'(exp_busy));
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat));
      @(negedge clk);
      checkOutput($sformatf("v%0d_done_width", i), 32'(done), 32'h0);
`ifndef MIPS_MD_DIV_EN
      model_hi = exp_hi;
      model_lo = exp_lo;
`endif
    end

    // A start arriving mid-multiply must not disturb the running operation.
    applyStimulus(MD_MULT, 32'd3, 32'd4);
    busy_pre = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) busy_pre++;
    end
    md_op     = MD_DIVU;
    operand_a = 32'd100;
    operand_b = 32'd0;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(100, busy_cnt, lat, seen);
    checkOutput("ign_done_seen", 32'(seen), 32'h1);
    checkOutput("ign_busy_cycles", 32'(busy_pre + busy_cnt), 32'd32);
    checkOutput("ign_latency", 32'(10 + lat), 32'd33);
    checkOutput("ign_hi", hi, 32'h0);
    checkOutput("ign_lo", lo, 32'd12);
    checkOutput("ign_dbz", 32'(div_by_zero), 32'h0);

    // Start presented during the DONE cycle is dropped.
    md_op     = MD_MTHI;
    operand_a = 32'h0000DEAD;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("done_start_hi", hi, 32'h0);
    checkOutput("done_start_done", 32'(done), 32'h0);

    applyStimulus(MD_MTHI, 32'h0000ABCD, 32'h0);
    @(negedge clk);
    checkOutput("mthi_hi", hi, 32'h0000ABCD);
    checkOutput("mthi_done", 32'(done), 32'h0);
    applyStimulus(MD_MTLO, 32'h00001234, 32'h0);
    @(negedge clk);
    checkOutput("mtlo_lo", lo, 32'h00001234);
    checkOutput("mtlo_hi", hi, 32'h0000ABCD);
    checkOutput("mtlo_done", 32'(done), 32'h0);
    checkOutput("mtlo_busy", 32'(busy), 32'h0);

    // Asynchronous reset in the middle of a long operation.
`ifdef MIPS_MD_DIV_EN
    seq_op = MD_DIV;
`else
    seq_op = MD_MULT;
`endif
    applyStimulus(seq_op, 32'hFFFFFFF9, 32'h00000002);
    repeat (14) @(negedge clk);
    checkOutput("mid_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("arst_hi", hi, 32'h0);
    checkOutput("arst_lo", lo, 32'h0);
    checkOutput("arst_busy", 32'(busy), 32'h0);
    checkOutput("arst_done", 32'(done), 32'h0);
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checkOutput("arst_no_done", 32'(saw_done), 32'h0);
    reset = 1'b0;

    applyStimulus(MD_MULT, 32'd6, 32'd7);
    waitDone(100, busy_cnt, lat, seen);
    checkOutput("post_done_seen", 32'(seen), 32'h1);
    checkOutput("post_hi", hi, 32'h0);
    checkOutput("post_lo", lo, 32'd42);
    checkOutput("post_busy_cycles", 32'(busy_cnt), 32'd32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mult_div.md
Name: mips_mult_div

Overview:
- Iterative multiply/divide unit directly downstream of the register file.
- Consumes read_data_1 (rs) and read_data_2 (rt) and holds the architectural HI/LO registers.
- Read by MFHI/MFLO and written by MTHI/MTLO.
- Uses a start/busy/done handshake so the control unit stalls while an operation runs.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- md_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
- operand_a  input  WIDTH  rs value (read_data_1)
- operand_b  input  WIDTH  rt value (read_data_2)
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  high while iterating (state RUN)
- done  output  1  one-cycle pulse when HI/LO hold a new mult/div result
- div_by_zero  output  1  sticky flag; set by DIV/DIVU with operand_b=0, cleared by the next accepted start

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE, counter=0.
- State IDLE:
  - start=1 with MULT/MULTU/DIV/DIVU latches the operands and sign info, sets counter=0, goes to RUN.
  - start=1 with MTHI writes operand_a to hi at that edge; MTLO writes operand_a to lo. Both stay in IDLE with no done pulse.
  - Undefined md_op: ignored.
- State RUN: one iteration per edge; 32 edges (counter 0..31). The edge with counter=31 writes hi/lo and goes to DONE.
- State DONE: done=1 for exactly one cycle, then unconditionally back to IDLE. start in DONE is ignored.
- Latency: start edge E0, busy=1 during cycles after E0..E32, results visible and done=1 in the cycle after E32. Back-to-back issue is possible at the earliest on the edge following DONE.
- start while busy or done is ignored. Operands and md_op are not re-sampled.
- Multiply:
  - Shift-add on 32-bit magnitudes into a 64-bit product; {hi,lo} = product.
  - Signed (MULT): magnitudes of two's-complement inputs; product negated if signs differ.
- Divide:
  - Restoring, one quotient bit per cycle; lo = quotient, hi = remainder.
  - Signed (DIV): quotient negated if signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero:
  - Still takes 32 cycles.
  - Result forced to hi=operand_a, lo=0xFFFFFFFF; div_by_zero set on entering DONE.
- Reset mid-operation aborts the operation. All outputs return to reset values immediately (asynchronous), with no done pulse.
- hi/lo change only on: DONE entry, MTHI/MTLO in IDLE, or reset.

Optional Feature:
- Macro: MIPS_MD_DIV_EN.
- Defined: full behaviour above.
- Undefined:
  - Divider datapath not built.
  - DIV/DIVU accepted in IDLE go straight to DONE (done pulses the next cycle, busy never asserted).
  - hi/lo unchanged; div_by_zero tied to 0.

Decomposition:
- Shared package mips_pkg holds:
  - md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO)
  - state encoding (ST_IDLE, ST_RUN, ST_DONE)
  - WIDTH constant
- One natural sub-module: mips_md_sign_fix (magnitude extraction and result negation, combinational), instantiated for inputs and outputs.
- FSM, counter and shift registers stay in mips_mult_div.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> after 33 edges done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high exactly 32 cycles.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> hi=0x00000064, lo=0xFFFFFFFF, div_by_zero=1; next accepted start clears the flag.
- Issue MULT, pulse start with DIVU and new operands at cycle 10 -> ignored, MULT result unchanged. MTLO 0x1234 in IDLE -> lo=0x1234 next cycle, no done.
- Assert reset at cycle 15 of a DIV -> hi=lo=0, busy=0, no done pulse. Release, then issue MULT 6*7 -> lo=42, hi=0.
- Build without MIPS_MD_DIV_EN, issue DIV -> busy never high, done one cycle after start edge, hi/lo unchanged.
